// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Control FSM for a multicycle MIPS datapath. It decodes the IR opcode and,
//   for each state, drives the {s1,s0} select pairs of the 4:1 PC-source and
//   ALU-src-B muxes together with every datapath enable.
//   Mux convention: {s1,s0} = 00 -> i1, 01 -> i2, 10 -> i3, 11 -> i4.
//
// Ports
//   clk                 in   rising-edge clock
//   reset               in   asynchronous, active-high; state returns to FETCH
//   opcode[5:0]         in   IR[31:26]; looked at only in DECODE and MEMADR
//   zero                in   ALU zero flag; matters only in BRANCH
//   pc_src_s1/s0        out  PC mux: 00 PC+4, 01 branch target, 10 jump, 11 exc vector
//   srcb_s1/s0          out  ALU B mux: 00 regB, 01 4, 10 imm, 11 imm<<2
//   alu_srca            out  ALU A: 0 PC, 1 regA
//   alu_op[1:0]         out  00 add, 01 sub, 10 use funct
//   pc_en               out  pc_write | (pc_write_cond & zero)
//   iord                out  memory address: 0 PC, 1 ALUOut
//   mem_read/mem_write  out  memory strobes
//   ir_write            out  IR load enable
//   reg_write           out  register file write enable
//   reg_dst             out  write register: 0 rt, 1 rd
//   mem_to_reg          out  write data: 0 ALUOut, 1 MDR
//   illegal_op          out  one-cycle pulse while in EXCEPT
//   state[3:0]          out  current state code (debug)
//
// Handshake note: this block has no valid/ready interface; every enable is a
// single-cycle qualifier that the datapath acts on at the next rising edge.

module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_src_s0,
  output logic       pc_src_s1,
  output logic       srcb_s0,
  output logic       srcb_s1,
  output logic       alu_srca,
  output logic [1:0] alu_op,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_EXCEPT = 4'd12
  } state_t;

  typedef struct packed {
    logic [1:0] pc_src;
    logic [1:0] srcb;
    logic       alu_srca;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
  } ctrl_t;

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;

  // Moore output table. Outputs are registered by decoding the *next* state,
  // so ctrl_q always holds the values belonging to state_q.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
        c.srcb     = 2'b01;
        c.pc_src   = 2'b00;
      end
      S_DECODE: c.srcb = 2'b11;  // precompute branch target into ALUOut
      S_MEMADR: begin
        c.alu_srca = 1'b1;
        c.srcb     = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_srca = 1'b1;
        c.srcb     = 2'b00;
        c.alu_op   = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_srca      = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_src        = 2'b01;
        c.pc_write_cond = 1'b1;
      end
      S_ADDIEX: begin
        c.alu_srca = 1'b1;
        c.srcb     = 2'b10;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
      S_EXCEPT: begin
        c.pc_write   = 1'b1;
        c.pc_src     = 2'b11;
        c.illegal_op = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; opcode is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_d = S_EXEC;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_ADDI)             state_d = S_ADDIEX;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else                                    state_d = S_EXCEPT;
      end
      // Only LW and SW reach MEMADR; anything but LW is treated as a store.
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end

  // Selects show FETCH values during reset; every enable and the illegal_op
  // pulse is gated directly by reset so an aborted instruction cannot write.
  assign pc_src_s1  = ctrl_q.pc_src[1];
  assign pc_src_s0  = ctrl_q.pc_src[0];
  assign srcb_s1    = ctrl_q.srcb[1];
  assign srcb_s0    = ctrl_q.srcb[0];
  assign alu_srca   = ctrl_q.alu_srca;
  assign alu_op     = ctrl_q.alu_op;
  assign iord       = ctrl_q.iord;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign pc_en      = ~reset & (ctrl_q.pc_write | (ctrl_q.pc_write_cond & zero));
  assign mem_read   = ~reset & ctrl_q.mem_read;
  assign mem_write  = ~reset & ctrl_q.mem_write;
  assign ir_write   = ~reset & ctrl_q.ir_write;
  assign reg_write  = ~reset & ctrl_q.reg_write;
  assign illegal_op = ~reset & ctrl_q.illegal_op;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed scenarios followed by random
// instruction streams, compared every cycle against a reference model that
// derives each instruction's state walk from its opcode.

module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_src_s0, pc_src_s1, srcb_s0, srcb_s1, alu_srca;
  logic [1:0] alu_op;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
  logic       reg_dst, mem_to_reg, illegal_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .pc_src_s0  (pc_src_s0),
    .pc_src_s1  (pc_src_s1),
    .srcb_s0    (srcb_s0),
    .srcb_s1    (srcb_s1),
    .alu_srca   (alu_srca),
    .alu_op     (alu_op),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal_op (illegal_op),
    .state      (state)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];   // expected state walk of the instruction in flight

  wire [15:0] obs_outs = {pc_src_s1, pc_src_s0, srcb_s1, srcb_s0, alu_srca, alu_op,
                          pc_en, iord, mem_read, mem_write, ir_write, reg_write,
                          reg_dst, mem_to_reg, illegal_op};

  // ---------------- reference model ----------------
  function automatic bit is_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_ADDI || op == OP_J;
  endfunction

  // The whole walk from FETCH back to just before the next FETCH.
  function automatic void build_walk(input logic [5:0] op);
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(1);
    case (op)
      OP_LW:    begin exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); end
      OP_SW:    begin exp_q.push_back(2); exp_q.push_back(5); end
      OP_RTYPE: begin exp_q.push_back(6); exp_q.push_back(7); end
      OP_ADDI:  begin exp_q.push_back(9); exp_q.push_back(10); end
      OP_BEQ:   exp_q.push_back(8);
      OP_J:     exp_q.push_back(11);
      default:  exp_q.push_back(12);
    endcase
  endfunction

  function automatic int walk_len(input logic [5:0] op);
    case (op)
      OP_LW:                     return 5;
      OP_SW, OP_RTYPE, OP_ADDI:  return 4;
      default:                   return 3;
    endcase
  endfunction

  // Output vector the datapath should see in a given state.
  function automatic logic [15:0] exp_outs(input int st, input logic z, input logic rst);
    logic [1:0] ps, sb, op;
    logic sa, pw, pwc, io, mr, mw, iw, rw, rd, m2r, il, pen;
    ps = 2'b00; sb = 2'b00; op = 2'b00;
    sa = 0; pw = 0; pwc = 0; io = 0; mr = 0; mw = 0; iw = 0;
    rw = 0; rd = 0; m2r = 0; il = 0;
    case (st)
      0:  begin mr = 1; iw = 1; pw = 1; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; io = 1; end
      6:  begin sa = 1; op = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; op = 2'b01; ps = 2'b01; pwc = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pw = 1; ps = 2'b10; end
      12: begin pw = 1; ps = 2'b11; il = 1; end
      default: ;
    endcase
    pen = pw | (pwc & z);
    if (rst) begin
      pen = 0; mr = 0; mw = 0; iw = 0; rw = 0; il = 0;
    end
    return {ps, sb, sa, op, pen, io, mr, mw, iw, rw, rd, m2r, il};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // zmode: 0 zero=0, 1 zero=1, 2 random. nsteps<0 runs the full walk.
  // scramble=1 randomises opcode in states where it must be ignored.
  task automatic run_instr(input logic [5:0] op, input int zmode, input int nsteps,
                           input bit scramble);
    int n;
    build_walk(op);
    n = (nsteps < 0) ? exp_q.size() : nsteps;
    check($sformatf("len_%02h", op), 16'(exp_q.size()), 16'(walk_len(op)));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) opcode = op;
      else if (scramble && exp_q[i] != 1 && exp_q[i] != 2) opcode = 6'($urandom);
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      #1;
      check($sformatf("state_op%02h_s%0d", op, i), {12'd0, state}, 16'(exp_q[i]));
      check($sformatf("outs_op%02h_s%0d", op, i), obs_outs, exp_outs(exp_q[i], zero, 1'b0));
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] op;
    logic [5:0] legal_ops[6];
    legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    reset  = 1'b1;
    opcode = OP_RTYPE;
    zero   = 1'b0;

    // power-on reset: FETCH selects, enables held low
    @(negedge clk); #1;
    check("reset_state", {12'd0, state}, 16'd0);
    check("reset_outs", obs_outs, exp_outs(0, zero, 1'b1));
    release_reset();

    // reset in ALUWB aborts the R-type write immediately
    run_instr(OP_RTYPE, 2, 4, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("abort_state", {12'd0, state}, 16'd0);
    check("abort_outs", obs_outs, exp_outs(0, zero, 1'b1));
    check("abort_reg_write", {15'd0, reg_write}, 16'd0);
    release_reset();

    // directed instructions (first FETCH check covers first post-reset cycle)
    run_instr(OP_LW, 2, -1, 1'b0);
    run_instr(OP_BEQ, 1, -1, 1'b0);
    run_instr(OP_BEQ, 0, -1, 1'b0);
    run_instr(OP_J, 2, -1, 1'b0);
    run_instr(6'b111111, 2, -1, 1'b0);
    run_instr(OP_RTYPE, 2, -1, 1'b0);
    run_instr(OP_ADDI, 2, -1, 1'b0);
    run_instr(OP_SW, 2, -1, 1'b0);

    // random instruction stream
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 6) == 6) begin
        op = 6'($urandom);
        for (int t = 0; t < 16 && is_legal(op); t++) op = 6'($urandom);
        if (is_legal(op)) op = 6'b111110;
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(op, 2, -1, 1'b1);
    end

    // random mid-instruction reset, then one more instruction
    for (int k = 0; k < 10; k++) begin
      op = legal_ops[$urandom_range(0, 5)];
      run_instr(op, 2, $urandom_range(1, walk_len(op)), 1'b0);
      #1 reset = 1'b1;
      #1;
      check("rand_abort_outs", obs_outs, exp_outs(0, zero, 1'b1));
      check("rand_abort_state", {12'd0, state}, 16'd0);
      release_reset();
    end
    run_instr(OP_LW, 2, -1, 1'b0);
    @(negedge clk); #1;
    check("final_state", {12'd0, state}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
